// File: rtl/vga_layer_arbiter.sv
// ---------------------------------------------------------------------------
// vga_layer_arbiter
//
// Purpose:
//   Sits between the VGA timing generator and the DAC pins and shares the
//   single pixel output between NUM_LAYERS rectangular layers by fixed
//   priority (layer 0 wins). Layer configuration is written over a
//   valid/ready port into a pending set, and the pending set is copied into
//   the active set only at frame start (falling edge of v_sync_in). A frame
//   therefore never shows a half-updated configuration.
//
//   Pixel path is a fixed 2-stage pipeline:
//     S1: one registered hit bit per layer, plus registered de
//     S2: lowest-index hit selects colour and index; background or black
//         otherwise
//   The sync signals pass through two flops so they stay aligned with
//   rgb_out.
//
// Optional feature (compile-time macro VGA_COLLISION_EN):
//   When defined, a sticky per-layer accumulator records every layer that
//   was hit together with at least one other layer during a frame. At each
//   commit the accumulator is published on collision and cleared, so
//   collision shows the previous frame's result for the whole frame. When
//   the macro is not defined, collision is tied to 0.
//
// Ports:
//   clk_vga               pixel clock
//   rst_vga               synchronous reset, active low
//   h_sync_in, v_sync_in  syncs from the timing generator (vsync active-low)
//   de_in, x_in, y_in     visible-pixel flag and position
//   cfg_valid/cfg_ready   config write handshake
//   cfg_layer, cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_color
//                         config payload (bounds are inclusive)
//   h_sync_out, v_sync_out  syncs delayed by 2 cycles
//   rgb_out               pixel colour aligned with the delayed syncs
//   hit_layer             winning layer index, NUM_LAYERS when none
//   frame_start           high during the commit cycle
//   collision             per-layer overlap flags of the previous frame
// ---------------------------------------------------------------------------
module vga_layer_arbiter #(
    parameter int                 NUM_LAYERS = 4,
    parameter int                 COORD_W    = 10,
    parameter int                 COLOR_W    = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0,
    localparam int                LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk_vga,
    input  logic                  rst_vga,
    input  logic                  h_sync_in,
    input  logic                  v_sync_in,
    input  logic                  de_in,
    input  logic [COORD_W-1:0]    x_in,
    input  logic [COORD_W-1:0]    y_in,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [LW-1:0]         cfg_layer,
    input  logic                  cfg_en,
    input  logic [COORD_W-1:0]    cfg_x0,
    input  logic [COORD_W-1:0]    cfg_x1,
    input  logic [COORD_W-1:0]    cfg_y0,
    input  logic [COORD_W-1:0]    cfg_y1,
    input  logic [COLOR_W-1:0]    cfg_color,
    output logic                  h_sync_out,
    output logic                  v_sync_out,
    output logic [COLOR_W-1:0]    rgb_out,
    output logic [LW:0]           hit_layer,
    output logic                  frame_start,
    output logic [NUM_LAYERS-1:0] collision
);

    // Pending and active layer sets
    logic [NUM_LAYERS-1:0] pend_en_reg;
    logic [NUM_LAYERS-1:0] act_en_reg;
    logic [COORD_W-1:0]    pend_x0_reg    [NUM_LAYERS];
    logic [COORD_W-1:0]    pend_x1_reg    [NUM_LAYERS];
    logic [COORD_W-1:0]    pend_y0_reg    [NUM_LAYERS];
    logic [COORD_W-1:0]    pend_y1_reg    [NUM_LAYERS];
    logic [COLOR_W-1:0]    pend_color_reg [NUM_LAYERS];
    logic [COORD_W-1:0]    act_x0_reg     [NUM_LAYERS];
    logic [COORD_W-1:0]    act_x1_reg     [NUM_LAYERS];
    logic [COORD_W-1:0]    act_y0_reg     [NUM_LAYERS];
    logic [COORD_W-1:0]    act_y1_reg     [NUM_LAYERS];
    logic [COLOR_W-1:0]    act_color_reg  [NUM_LAYERS];

    // Pipeline state
    logic                  ready_reg;
    logic                  h1_reg, h2_reg, v1_reg, v2_reg;
    logic                  de1_reg;
    logic [NUM_LAYERS-1:0] hit_reg;
    logic [COLOR_W-1:0]    rgb_reg;
    logic [LW:0]           hit_layer_reg;

    logic                  commit;
    logic                  accept;
    logic [NUM_LAYERS-1:0] wr_sel;
    logic [NUM_LAYERS-1:0] hit_next;
    logic [COLOR_W-1:0]    color_next;
    logic [COLOR_W-1:0]    rgb_next;
    logic [LW:0]           hit_layer_next;

    // Commit on the falling edge of vsync. Gating with rst_vga keeps every
    // combinational output low while reset is asserted.
    assign commit      = rst_vga & v1_reg & ~v_sync_in;
    assign cfg_ready   = rst_vga & ready_reg & ~commit;
    assign accept      = cfg_valid & cfg_ready;
    assign frame_start = commit;

    // Per-layer write decode and S1 hit compare. A cfg_layer value with no
    // matching layer selects nothing, so the write is accepted and dropped.
    // An empty box (x0 > x1 or y0 > y1) can never satisfy both compares.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            assign wr_sel[gi]   = accept && (cfg_layer == LW'(gi));
            assign hit_next[gi] = act_en_reg[gi] && de_in
                               && (x_in >= act_x0_reg[gi]) && (x_in <= act_x1_reg[gi])
                               && (y_in >= act_y0_reg[gi]) && (y_in <= act_y1_reg[gi]);
        end
    endgenerate

    // S2: lowest-index hit wins; scanning downward lets the lowest index
    // overwrite the others.
    always_comb begin
        hit_layer_next = (LW+1)'(NUM_LAYERS);
        color_next     = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_reg[i]) begin
                hit_layer_next = (LW+1)'(i);
                color_next     = act_color_reg[i];
            end
        end
        if (hit_reg != '0)
            rgb_next = color_next;
        else if (de1_reg)
            rgb_next = BG_COLOR;
        else
            rgb_next = '0;
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_vga) begin
            ready_reg     <= 1'b0;
            h1_reg        <= 1'b0;
            h2_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            de1_reg       <= 1'b0;
            hit_reg       <= '0;
            rgb_reg       <= '0;
            hit_layer_reg <= (LW+1)'(NUM_LAYERS);
            pend_en_reg   <= '0;
            act_en_reg    <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                pend_x0_reg[i]    <= '0;
                pend_x1_reg[i]    <= '0;
                pend_y0_reg[i]    <= '0;
                pend_y1_reg[i]    <= '0;
                pend_color_reg[i] <= '0;
                act_x0_reg[i]     <= '0;
                act_x1_reg[i]     <= '0;
                act_y0_reg[i]     <= '0;
                act_y1_reg[i]     <= '0;
                act_color_reg[i]  <= '0;
            end
        end else begin
            ready_reg     <= 1'b1;
            h1_reg        <= h_sync_in;
            h2_reg        <= h1_reg;
            v1_reg        <= v_sync_in;
            v2_reg        <= v1_reg;
            de1_reg       <= de_in;
            hit_reg       <= hit_next;
            rgb_reg       <= rgb_next;
            hit_layer_reg <= hit_layer_next;
            // Writes and commits never share a cycle because cfg_ready is
            // low during the commit cycle.
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (wr_sel[i]) begin
                    pend_en_reg[i]    <= cfg_en;
                    pend_x0_reg[i]    <= cfg_x0;
                    pend_x1_reg[i]    <= cfg_x1;
                    pend_y0_reg[i]    <= cfg_y0;
                    pend_y1_reg[i]    <= cfg_y1;
                    pend_color_reg[i] <= cfg_color;
                end
                if (commit) begin
                    act_en_reg[i]    <= pend_en_reg[i];
                    act_x0_reg[i]    <= pend_x0_reg[i];
                    act_x1_reg[i]    <= pend_x1_reg[i];
                    act_y0_reg[i]    <= pend_y0_reg[i];
                    act_y1_reg[i]    <= pend_y1_reg[i];
                    act_color_reg[i] <= pend_color_reg[i];
                end
            end
        end
    end

    assign h_sync_out = h2_reg;
    assign v_sync_out = v2_reg;
    assign rgb_out    = rgb_reg;
    assign hit_layer  = hit_layer_reg;

`ifdef VGA_COLLISION_EN
    logic [NUM_LAYERS-1:0] coll_acc_reg;
    logic [NUM_LAYERS-1:0] coll_reg;
    logic                  multi_hit;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_hit = |(hit_reg & (hit_reg - NUM_LAYERS'(1)));

    always_ff @(posedge clk_vga) begin
        if (!rst_vga) begin
            coll_acc_reg <= '0;
            coll_reg     <= '0;
        end else if (commit) begin
            // Clearing wins over a same-cycle overlap.
            coll_reg     <= coll_acc_reg;
            coll_acc_reg <= '0;
        end else if (multi_hit) begin
            coll_acc_reg <= coll_acc_reg | hit_reg;
        end
    end

    assign collision = coll_reg;
`else
    assign collision = '0;
`endif

endmodule

// File: tb/tb_vga_layer_arbiter.sv
module tb_vga_layer_arbiter;

    logic       clk_vga = 1'b0;
    logic       rst_vga;
    logic       h_sync_in, v_sync_in, de_in;
    logic [9:0] x_in, y_in;
    logic       cfg_valid, cfg_ready;
    logic [1:0] cfg_layer;
    logic       cfg_en;
    logic [9:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
    logic [7:0] cfg_color;
    logic       h_sync_out, v_sync_out;
    logic [7:0] rgb_out;
    logic [2:0] hit_layer;
    logic       frame_start;
    logic [3:0] collision;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [7:0] BG = 8'h49;

`ifdef VGA_COLLISION_EN
    localparam logic [3:0] EXP_C0011 = 4'b0011;
    localparam logic [3:0] EXP_C1001 = 4'b1001;
`else
    localparam logic [3:0] EXP_C0011 = 4'b0000;
    localparam logic [3:0] EXP_C1001 = 4'b0000;
`endif

    vga_layer_arbiter #(
        .NUM_LAYERS (4),
        .COORD_W    (10),
        .COLOR_W    (8),
        .BG_COLOR   (BG)
    ) dut (
        .clk_vga     (clk_vga),
        .rst_vga     (rst_vga),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .de_in       (de_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_layer   (cfg_layer),
        .cfg_en      (cfg_en),
        .cfg_x0      (cfg_x0),
        .cfg_x1      (cfg_x1),
        .cfg_y0      (cfg_y0),
        .cfg_y1      (cfg_y1),
        .cfg_color   (cfg_color),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .rgb_out     (rgb_out),
        .hit_layer   (hit_layer),
        .frame_start (frame_start),
        .collision   (collision)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic tick;
        @(posedge clk_vga);
        #1;
    endtask

    // Present one pixel for a single cycle, then blank, and advance until
    // its result is on rgb_out/hit_layer.
    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic de);
        x_in  = x;
        y_in  = y;
        de_in = de;
        tick;
        de_in = 1'b0;
        tick;
        $display("pixel x=%0d y=%0d de=%0b -> rgb=%h hit=%0d", x, y, de, rgb_out, hit_layer);
    endtask

    task automatic cfg_write(input logic [1:0] layer, input logic en,
                             input logic [9:0] x0, input logic [9:0] x1,
                             input logic [9:0] y0, input logic [9:0] y1,
                             input logic [7:0] color);
        cfg_layer = layer;
        cfg_en    = en;
        cfg_x0    = x0;
        cfg_x1    = x1;
        cfg_y0    = y0;
        cfg_y1    = y1;
        cfg_color = color;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        $display("cfg layer=%0d en=%0b x=%0d..%0d y=%0d..%0d color=%h", layer, en, x0, x1, y0, y1, color);
    endtask

    task automatic do_commit;
        v_sync_in = 1'b0;
        tick;
        v_sync_in = 1'b1;
        tick;
        $display("commit done, collision=%b", collision);
    endtask

    task automatic test_reset;
        rst_vga = 1'b0;
        x_in = 10'd100; y_in = 10'd100; de_in = 1'b1;
        h_sync_in = 1'b1; v_sync_in = 1'b1;
        tick; tick; tick;
        $display("reset held 3 cycles: rgb=%h hit=%0d ready=%0b", rgb_out, hit_layer, cfg_ready);
        n_cmp++; if (rgb_out !== 8'h00) begin n_err++; $display("FAIL reset_rgb: got %h expected %h", rgb_out, 8'h00); end
        n_cmp++; if (hit_layer !== 3'd4) begin n_err++; $display("FAIL reset_hit: got %0d expected %0d", hit_layer, 4); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        n_cmp++; if (h_sync_out !== 1'b0 || v_sync_out !== 1'b0) begin n_err++; $display("FAIL reset_syncs: got h=%b v=%b expected 0 0", h_sync_out, v_sync_out); end
        n_cmp++; if (collision !== 4'b0000) begin n_err++; $display("FAIL reset_collision: got %b expected 0000", collision); end
        rst_vga = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_same_cycle: got %b expected 0", cfg_ready); end
        tick;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b expected 1", cfg_ready); end
        n_cmp++; if (h_sync_out !== 1'b0) begin n_err++; $display("FAIL sync_delay1: got %b expected 0", h_sync_out); end
        tick;
        $display("after release: h=%b v=%b rgb=%h hit=%0d", h_sync_out, v_sync_out, rgb_out, hit_layer);
        n_cmp++; if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin n_err++; $display("FAIL sync_delay2: got h=%b v=%b expected 1 1", h_sync_out, v_sync_out); end
        n_cmp++; if (rgb_out !== BG) begin n_err++; $display("FAIL release_bg: got %h expected %h", rgb_out, BG); end
        n_cmp++; if (hit_layer !== 3'd4) begin n_err++; $display("FAIL release_hit: got %0d expected 4", hit_layer); end
        de_in = 1'b0;
        tick;
    endtask

    task automatic test_commit_latency;
        cfg_write(2'd2, 1'b1, 10'd10, 10'd20, 10'd10, 10'd20, 8'hE0);
        pixel(10'd15, 10'd15, 1'b1);
        n_cmp++; if (rgb_out !== BG) begin n_err++; $display("FAIL pending_not_active_rgb: got %h expected %h", rgb_out, BG); end
        n_cmp++; if (hit_layer !== 3'd4) begin n_err++; $display("FAIL pending_not_active_hit: got %0d expected 4", hit_layer); end
        do_commit;
        pixel(10'd0, 10'd0, 1'b1);
        n_cmp++; if (rgb_out !== BG) begin n_err++; $display("FAIL uncovered_rgb: got %h expected %h", rgb_out, BG); end
        x_in = 10'd15; y_in = 10'd15; de_in = 1'b1;
        tick;
        de_in = 1'b0;
        $display("latency step 1: rgb=%h hit=%0d", rgb_out, hit_layer);
        n_cmp++; if (rgb_out !== 8'h00) begin n_err++; $display("FAIL latency_early: got %h expected %h", rgb_out, 8'h00); end
        tick;
        $display("latency step 2: rgb=%h hit=%0d", rgb_out, hit_layer);
        n_cmp++; if (rgb_out !== 8'hE0) begin n_err++; $display("FAIL commit_rgb: got %h expected %h", rgb_out, 8'hE0); end
        n_cmp++; if (hit_layer !== 3'd2) begin n_err++; $display("FAIL commit_hit: got %0d expected 2", hit_layer); end
    endtask

    task automatic test_priority;
        cfg_write(2'd0, 1'b1, 10'd40, 10'd60, 10'd40, 10'd60, 8'h1C);
        cfg_write(2'd3, 1'b1, 10'd45, 10'd70, 10'd45, 10'd70, 8'h03);
        do_commit;
        n_cmp++; if (collision !== 4'b0000) begin n_err++; $display("FAIL prio_collision_prev: got %b expected 0000", collision); end
        pixel(10'd50, 10'd50, 1'b1);
        n_cmp++; if (rgb_out !== 8'h1C) begin n_err++; $display("FAIL prio_rgb: got %h expected %h", rgb_out, 8'h1C); end
        n_cmp++; if (hit_layer !== 3'd0) begin n_err++; $display("FAIL prio_hit: got %0d expected 0", hit_layer); end
        pixel(10'd65, 10'd65, 1'b1);
        n_cmp++; if (rgb_out !== 8'h03) begin n_err++; $display("FAIL layer3_rgb: got %h expected %h", rgb_out, 8'h03); end
        n_cmp++; if (hit_layer !== 3'd3) begin n_err++; $display("FAIL layer3_hit: got %0d expected 3", hit_layer); end
        pixel(10'd15, 10'd15, 1'b1);
        n_cmp++; if (rgb_out !== 8'hE0 || hit_layer !== 3'd2) begin n_err++; $display("FAIL layer2_kept: got %h/%0d expected e0/2", rgb_out, hit_layer); end
    endtask

    task automatic test_boundaries;
        cfg_write(2'd0, 1'b1, 10'd30, 10'd29, 10'd0, 10'd479, 8'hAA);
        cfg_write(2'd1, 1'b1, 10'd0, 10'd639, 10'd0, 10'd479, 8'hF0);
        cfg_write(2'd2, 1'b0, 10'd0, 10'd639, 10'd0, 10'd479, 8'hE0);
        cfg_write(2'd3, 1'b0, 10'd0, 10'd639, 10'd0, 10'd479, 8'h03);
        do_commit;
        n_cmp++; if (collision !== EXP_C1001) begin n_err++; $display("FAIL prio_frame_collision: got %b expected %b", collision, EXP_C1001); end
        pixel(10'd0, 10'd0, 1'b1);
        n_cmp++; if (rgb_out !== 8'hF0 || hit_layer !== 3'd1) begin n_err++; $display("FAIL bound_x0: got %h/%0d expected f0/1", rgb_out, hit_layer); end
        pixel(10'd639, 10'd479, 1'b1);
        n_cmp++; if (rgb_out !== 8'hF0 || hit_layer !== 3'd1) begin n_err++; $display("FAIL bound_x639: got %h/%0d expected f0/1", rgb_out, hit_layer); end
        pixel(10'd30, 10'd10, 1'b1);
        n_cmp++; if (rgb_out !== 8'hF0 || hit_layer !== 3'd1) begin n_err++; $display("FAIL empty_box_30: got %h/%0d expected f0/1", rgb_out, hit_layer); end
        pixel(10'd29, 10'd10, 1'b1);
        n_cmp++; if (rgb_out !== 8'hF0 || hit_layer !== 3'd1) begin n_err++; $display("FAIL empty_box_29: got %h/%0d expected f0/1", rgb_out, hit_layer); end
        pixel(10'd100, 10'd100, 1'b0);
        n_cmp++; if (rgb_out !== 8'h00 || hit_layer !== 3'd4) begin n_err++; $display("FAIL blanking: got %h/%0d expected 00/4", rgb_out, hit_layer); end
        pixel(10'd640, 10'd100, 1'b1);
        n_cmp++; if (rgb_out !== BG || hit_layer !== 3'd4) begin n_err++; $display("FAIL bg_outside: got %h/%0d expected %h/4", rgb_out, hit_layer, BG); end
    endtask

    task automatic test_handshake;
        cfg_layer = 2'd1; cfg_en = 1'b1;
        cfg_x0 = 10'd0; cfg_x1 = 10'd5; cfg_y0 = 10'd0; cfg_y1 = 10'd5;
        cfg_color = 8'h11;
        cfg_valid = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_idle: got %b expected 1", cfg_ready); end
        tick;
        $display("handshake write color=11 accepted");
        cfg_color = 8'h22;
        tick;
        $display("handshake write color=22 accepted");
        cfg_color = 8'h33;
        v_sync_in = 1'b0;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_commit: got %b expected 0", cfg_ready); end
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL hs_frame_start: got %b expected 1", frame_start); end
        tick;
        v_sync_in = 1'b1;
        cfg_valid = 1'b0;
        #1;
        $display("after commit cycle: ready=%b frame_start=%b", cfg_ready, frame_start);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_after: got %b expected 1", cfg_ready); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL hs_frame_start_after: got %b expected 0", frame_start); end
        tick;
        pixel(10'd2, 10'd2, 1'b1);
        n_cmp++; if (rgb_out !== 8'h22 || hit_layer !== 3'd1) begin n_err++; $display("FAIL last_write_wins: got %h/%0d expected 22/1", rgb_out, hit_layer); end
        do_commit;
        pixel(10'd2, 10'd2, 1'b1);
        n_cmp++; if (rgb_out !== 8'h22) begin n_err++; $display("FAIL no_write_in_commit: got %h expected %h", rgb_out, 8'h22); end
    endtask

    task automatic test_collision;
        cfg_write(2'd0, 1'b1, 10'd0, 10'd10, 10'd0, 10'd10, 8'h1C);
        do_commit;
        n_cmp++; if (collision !== 4'b0000) begin n_err++; $display("FAIL coll_before: got %b expected 0000", collision); end
        pixel(10'd3, 10'd3, 1'b1);
        n_cmp++; if (rgb_out !== 8'h1C || hit_layer !== 3'd0) begin n_err++; $display("FAIL coll_pixel: got %h/%0d expected 1c/0", rgb_out, hit_layer); end
        n_cmp++; if (collision !== 4'b0000) begin n_err++; $display("FAIL coll_stable: got %b expected 0000", collision); end
        do_commit;
        n_cmp++; if (collision !== EXP_C0011) begin n_err++; $display("FAIL coll_published: got %b expected %b", collision, EXP_C0011); end
        cfg_write(2'd0, 1'b0, 10'd0, 10'd10, 10'd0, 10'd10, 8'h1C);
        n_cmp++; if (collision !== EXP_C0011) begin n_err++; $display("FAIL coll_held: got %b expected %b", collision, EXP_C0011); end
        do_commit;
        n_cmp++; if (collision !== 4'b0000) begin n_err++; $display("FAIL coll_cleared: got %b expected 0000", collision); end
        pixel(10'd3, 10'd3, 1'b1);
        n_cmp++; if (rgb_out !== 8'h22 || hit_layer !== 3'd1) begin n_err++; $display("FAIL coll_removed_pixel: got %h/%0d expected 22/1", rgb_out, hit_layer); end
    endtask

    task automatic test_mid_frame_reset;
        rst_vga = 1'b0;
        tick;
        $display("mid-frame reset: rgb=%h hit=%0d ready=%b", rgb_out, hit_layer, cfg_ready);
        n_cmp++; if (rgb_out !== 8'h00 || hit_layer !== 3'd4) begin n_err++; $display("FAIL mid_reset_out: got %h/%0d expected 00/4", rgb_out, hit_layer); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready: got %b expected 0", cfg_ready); end
        rst_vga = 1'b1;
        tick;
        pixel(10'd2, 10'd2, 1'b1);
        n_cmp++; if (rgb_out !== BG || hit_layer !== 3'd4) begin n_err++; $display("FAIL mid_reset_active_cleared: got %h/%0d expected %h/4", rgb_out, hit_layer, BG); end
        do_commit;
        pixel(10'd2, 10'd2, 1'b1);
        n_cmp++; if (rgb_out !== BG || hit_layer !== 3'd4) begin n_err++; $display("FAIL mid_reset_pending_cleared: got %h/%0d expected %h/4", rgb_out, hit_layer, BG); end
    endtask

    initial begin
        cfg_valid = 1'b0; cfg_layer = 2'd0; cfg_en = 1'b0;
        cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0; cfg_color = '0;
        test_reset;
        test_commit_latency;
        test_priority;
        test_boundaries;
        test_handshake;
        test_collision;
        test_mid_frame_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
